univ_shiftreg: RTL
==================

UNIV_SHIFTREG -- requirements
Module: univ_shiftreg

Interface
REQ-001 Parameter WIDTH, default 8, register length in bits; legal range 2..64.
REQ-002 Parameter CNTW, default $clog2(WIDTH+1), shift-counter width; derived, not overridden.
REQ-003 clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 rot  input  1  1 = rotate (shifted-out bit re-enters); 0 = serial input used.
REQ-007 sin_r  input  1  serial input entering the MSB on right shift.
REQ-008 sin_l  input  1  serial input entering the LSB on left shift.
REQ-009 pin  input  WIDTH  parallel load data.
REQ-010 q  output  WIDTH  register contents.
REQ-011 sout  output  1  registered copy of the bit most recently shifted out.
REQ-012 cnt  output  CNTW  shifts completed since last load or reset, saturating at WIDTH.
REQ-013 done  output  1  one-cycle pulse, high when cnt reaches WIDTH.

Function
REQ-014 All state updates SHALL occur on the rising edge of clk; mode, rot, sin_r, sin_l and pin are sampled at that edge.
REQ-015 Hold (00): q, sout and cnt unchanged; done SHALL be 0.
REQ-016 Shift right (01): q <= {rot ? q[0] : sin_r, q[WIDTH-1:1]}; sout <= q[0].
REQ-017 Shift left (10): q <= {q[WIDTH-2:0], rot ? q[WIDTH-1] : sin_l}; sout <= q[WIDTH-1].
REQ-018 Parallel load (11): q <= pin; sout <= 0; cnt <= 0; done <= 0; rot ignored.
REQ-019 Each shift edge with cnt < WIDTH SHALL increment cnt by 1; at cnt == WIDTH further shifts leave cnt at WIDTH (no wrap).
REQ-020 done SHALL be 1 for exactly the one cycle following the edge on which cnt changes from WIDTH-1 to WIDTH, and 0 otherwise; continued shifting at saturation SHALL NOT re-pulse done.
REQ-021 Mixing left and right shifts SHALL count each shift equally toward cnt.
REQ-022 Output latency: q, sout, cnt, done reflect an edge's operation immediately after that edge (one register stage, no combinational input-to-output paths).
REQ-023 Load on the cycle after saturation SHALL clear cnt and allow a fresh done pulse after WIDTH further shifts.

Reset
REQ-024 clr low SHALL immediately force q = 0, sout = 0, cnt = 0, done = 0, independent of clk.
REQ-025 While clr is low, all clock edges SHALL be ignored; reset asserted mid-sequence discards the partial count.
REQ-026 The first rising edge with clr high SHALL perform the operation selected by mode.

Structure
REQ-027 Mode encodings (HOLD, SHR, SHL, LOAD) SHALL be defined as named constants in a shared package shiftreg_pkg, used by RTL and bench.
REQ-028 The saturating shift counter with done-pulse generation SHALL be a sub-module named shift_cnt, parameterised by WIDTH; the data path stays in univ_shiftreg.

Verification (WIDTH=4 unless stated)
REQ-029 clr low at t=2, high at t=7, then mode=01, rot=0, sin_r stream 0,0,1,1 -> q = 0000, 0000, 1000, 1100; cnt = 1,2,3,4; done high only the cycle after the 4th shift.
REQ-030 Load pin=1011, then 4x shift left with rot=1 -> q = 0111, 1110, 1101, 1011; sout = 1,0,1,1; q restored to 1011 after 4 shifts.
REQ-031 Load pin=1001, 6x shift right with sin_r=0 -> cnt saturates at 4, single done pulse, q = 0000, sout = 0 after last shift.
REQ-032 Load 1111, 2 shifts, assert clr asynchronously between edges -> q, sout, cnt, done all 0 before next edge; after release, 4 shifts required for done.
REQ-033 Load 0110, hold for 3 cycles -> q = 0110, cnt = 0, done = 0 throughout; then load 0001 at cnt=4 -> cnt = 0 next cycle.
REQ-034 WIDTH=8: load 8'hA5, 8x shift right rot=0 sin_r=1 -> sout sequence 1,0,1,0,0,1,0,1; q = 8'hFF; done pulse after 8th shift.

Source files
------------

// File: rtl/univ_shiftreg_pkg.sv
// Shared constants for the universal shift register: operating-mode encodings.
// Combinational definitions only; no latency, no flow control.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/univ_shiftreg_if.sv
// Control/data bundle between a driver (master) and the shift register (slave).
// Signal wiring only; no latency, no backpressure.
interface univ_shiftreg_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
);

  logic [1:0]       mode;
  logic             rot;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CNTW-1:0]  cnt;
  logic             done;

  modport master (
    output mode, rot, sin_r, sin_l, pin,
    input  q, sout, cnt, done
  );

  modport slave (
    input  mode, rot, sin_r, sin_l, pin,
    output q, sout, cnt, done
  );

endinterface

// File: rtl/univ_shiftreg_shift_cnt.sv
// Saturating shift counter with a single done pulse when it first reaches WIDTH.
// One register stage; never stalls, load has priority over shift.
module shift_cnt #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            shift_en,
  input  logic            load,
  output logic [CNTW-1:0] cnt,
  output logic            done
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  // done fires only on the WIDTH-1 -> WIDTH step, so saturated shifting stays quiet
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (shift_en && (cnt_q != CNTW'(WIDTH))) begin
      cnt_d  = cnt_q + CNTW'(1);
      done_d = (cnt_q == CNTW'(WIDTH - 1));
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shiftreg.sv
// Universal shift register: hold, shift right/left (serial or rotate), parallel load.
// All outputs registered, one cycle after the sampling edge; no backpressure.
module univ_shiftreg
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           clr,
  univ_shiftreg_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CNTW-1:0]  cnt_w;
  logic             done_w;
  logic             shift_en;
  logic             load;
  mode_e            md;

  assign md       = mode_e'(bus.mode);
  assign shift_en = (md == SHR) || (md == SHL);
  assign load     = (md == LOAD);

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    case (md)
      SHR: begin
        q_d    = {(bus.rot ? q_q[0] : bus.sin_r), q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      SHL: begin
        q_d    = {q_q[WIDTH-2:0], (bus.rot ? q_q[WIDTH-1] : bus.sin_l)};
        sout_d = q_q[WIDTH-1];
      end
      LOAD: begin
        q_d    = bus.pin;
        sout_d = 1'b0;
      end
      default: begin
        q_d    = q_q;
        sout_d = sout_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q    <= '0;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  shift_cnt #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_shift_cnt (
    .clk      (clk),
    .clr      (clr),
    .shift_en (shift_en),
    .load     (load),
    .cnt      (cnt_w),
    .done     (done_w)
  );

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.cnt  = cnt_w;
  assign bus.done = done_w;

endmodule
